// File: rtl/i2c_lat_pkg.sv
// Shared definitions for the I2C hard-core transaction sequencer: register map,
// CMDR/SR encodings, response codes and sequencer states.
package i2c_lat_pkg;

    localparam logic [7:0] OFS_CR   = 8'h00;
    localparam logic [7:0] OFS_CMDR = 8'h01;
    localparam logic [7:0] OFS_BR0  = 8'h02;
    localparam logic [7:0] OFS_BR1  = 8'h03;
    localparam logic [7:0] OFS_TXDR = 8'h04;
    localparam logic [7:0] OFS_SR   = 8'h05;
    localparam logic [7:0] OFS_RXDR = 8'h07;

    localparam logic [7:0] CMD_STA    = 8'h80;
    localparam logic [7:0] CMD_STO    = 8'h40;
    localparam logic [7:0] CMD_RD     = 8'h20;
    localparam logic [7:0] CMD_WR     = 8'h10;
    localparam logic [7:0] CMD_NACK   = 8'h08;
    localparam logic [7:0] CMD_CKSDIS = 8'h04;

    // Composite commands issued by the sequencer (clock stretching disabled throughout)
    localparam logic [7:0] CMDR_START_WR = CMD_STA | CMD_WR | CMD_CKSDIS;
    localparam logic [7:0] CMDR_WR       = CMD_WR | CMD_CKSDIS;
    localparam logic [7:0] CMDR_RD_NACK  = CMD_RD | CMD_NACK | CMD_CKSDIS;
    localparam logic [7:0] CMDR_STOP     = CMD_STO | CMD_CKSDIS;
    localparam logic [7:0] CR_ENABLE     = 8'h80;

    localparam int SR_TRRDY = 2;
    localparam int SR_ARBL  = 3;
    localparam int SR_RARC  = 5;
    localparam int SR_BUSY  = 6;

    typedef enum logic [1:0] {
        ERR_OK   = 2'd0,
        ERR_NACK = 2'd1,
        ERR_TMO  = 2'd2,
        ERR_ARB  = 2'd3
    } rsp_err_e;

    typedef enum logic [3:0] {
        ST_INIT      = 4'd0,
        ST_IDLE      = 4'd1,
        ST_TX        = 4'd2,
        ST_CMD       = 4'd3,
        ST_POLL      = 4'd4,
        ST_RX        = 4'd5,
        ST_STOP      = 4'd6,
        ST_STOP_POLL = 4'd7,
        ST_DONE      = 4'd8
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lat_bus_mst.sv
// Single-access master for the I2C core register bus: strobe and payload are
// launched together and held until acknowledged, then the strobe drops for a cycle.
module lat_bus_mst (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic       busy,
    output logic [7:0] rdata,
    output logic       lat_stb,
    output logic       lat_we,
    output logic [7:0] lat_addr,
    output logic [7:0] lat_wdata,
    input  logic [7:0] lat_rdata,
    input  logic       lat_ack
);

    logic       stb_q, stb_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    // Launch, hold and retire one access; start is ignored while an access is open
    always_comb begin
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (stb_q) begin
            if (lat_ack) begin
                stb_d   = 1'b0;
                we_d    = 1'b0;
                addr_d  = 8'h00;
                wdata_d = 8'h00;
            end else begin
                stb_d   = 1'b1;
            end
        end else if (start) begin
            stb_d   = 1'b1;
            we_d    = we;
            addr_d  = addr;
            wdata_d = wdata;
        end else begin
            stb_d   = 1'b0;
        end
    end

    // Bus request registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign done      = stb_q & lat_ack;
    assign busy      = stb_q;
    assign rdata     = lat_rdata;
    assign lat_stb   = stb_q;
    assign lat_we    = we_q;
    assign lat_addr  = addr_q;
    assign lat_wdata = wdata_q;

endmodule

// File: rtl/i2c_lat_seq.sv
// Byte read/write sequencer for the I2C hard core: initialises the core, then
// expands each command into TXDR/CMDR/SR/RXDR accesses and reports data and status.
module i2c_lat_seq
    import i2c_lat_pkg::*;
#(
    parameter logic [7:0]  BASE     = 8'h40,
    parameter logic [9:0]  PRESCALE = 10'd60,
    parameter logic [15:0] POLL_MAX = 16'd4096
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       lat_stb,
    output logic       lat_we,
    output logic [7:0] lat_addr,
    output logic [7:0] lat_wdata,
    input  logic [7:0] lat_rdata,
    input  logic       lat_ack,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic       rd_q, rd_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    rsp_err_e   err_q, err_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [15:0] poll_inc_s;
    logic [7:0] tx_byte_s, cmd_byte_s;

    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0] rsp_err_q, rsp_err_d;
    logic       busy_q, busy_d;

    logic       mst_start_s, mst_we_s, mst_done_s, mst_busy_s;
    logic [7:0] mst_addr_s, mst_wdata_s, mst_rdata_s;

    lat_bus_mst u_bus (
        .clk       (clk),
        .resetn    (resetn),
        .start     (mst_start_s),
        .we        (mst_we_s),
        .addr      (mst_addr_s),
        .wdata     (mst_wdata_s),
        .done      (mst_done_s),
        .busy      (mst_busy_s),
        .rdata     (mst_rdata_s),
        .lat_stb   (lat_stb),
        .lat_we    (lat_we),
        .lat_addr  (lat_addr),
        .lat_wdata (lat_wdata),
        .lat_rdata (lat_rdata),
        .lat_ack   (lat_ack)
    );

    // Byte and command for the current program step; step 3 exists only on reads
    always_comb begin
        case (step_q)
            2'd0:    begin tx_byte_s = {dev_q, 1'b0}; cmd_byte_s = CMDR_START_WR; end
            2'd1:    begin tx_byte_s = addr_q;        cmd_byte_s = CMDR_WR;       end
            2'd2:    begin
                tx_byte_s  = rd_q ? {dev_q, 1'b1} : wdata_q;
                cmd_byte_s = rd_q ? CMDR_START_WR : CMDR_WR;
            end
            default: begin tx_byte_s = 8'h00;         cmd_byte_s = CMDR_RD_NACK;  end
        endcase
    end

    // Sequencer next state, bus requests and registered response outputs
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        rd_d        = rd_q;
        dev_d       = dev_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        poll_cnt_d  = poll_cnt_q;
        poll_inc_s  = sat_inc16(poll_cnt_q);
        mst_start_s = 1'b0;
        mst_we_s    = 1'b0;
        mst_addr_s  = 8'h00;
        mst_wdata_s = 8'h00;

        case (state_q)
            ST_INIT: begin
                mst_start_s = ~mst_busy_s;
                mst_we_s    = 1'b1;
                case (step_q)
                    2'd0:    begin mst_addr_s = BASE + OFS_BR0; mst_wdata_s = PRESCALE[7:0];         end
                    2'd1:    begin mst_addr_s = BASE + OFS_BR1; mst_wdata_s = {6'b0, PRESCALE[9:8]}; end
                    default: begin mst_addr_s = BASE + OFS_CR;  mst_wdata_s = CR_ENABLE;             end
                endcase
                if (mst_done_s && (step_q == 2'd2)) begin
                    state_d = ST_IDLE;
                    step_d  = 2'd0;
                end else if (mst_done_s) begin
                    step_d  = step_q + 2'd1;
                end else begin
                    step_d  = step_q;
                end
            end
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rd_d    = cmd_rd;
                    dev_d   = cmd_dev;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rdata_d = 8'h00;
                    err_d   = ERR_OK;
                    step_d  = 2'd0;
                    state_d = ST_TX;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TX: begin
                mst_start_s = ~mst_busy_s;
                mst_we_s    = 1'b1;
                mst_addr_s  = BASE + OFS_TXDR;
                mst_wdata_s = tx_byte_s;
                state_d     = mst_done_s ? ST_CMD : ST_TX;
            end
            ST_CMD: begin
                mst_start_s = ~mst_busy_s;
                mst_we_s    = 1'b1;
                mst_addr_s  = BASE + OFS_CMDR;
                mst_wdata_s = cmd_byte_s;
                if (mst_done_s) begin
                    state_d    = ST_POLL;
                    poll_cnt_d = 16'd0;
                end else begin
                    state_d    = ST_CMD;
                end
            end
            ST_POLL: begin
                mst_start_s = ~mst_busy_s;
                mst_addr_s  = BASE + OFS_SR;
                if (!mst_done_s) begin
                    state_d = ST_POLL;
                end else if (!mst_rdata_s[SR_TRRDY]) begin
                    poll_cnt_d = poll_inc_s;
                    if (poll_inc_s >= POLL_MAX) begin
                        err_d   = ERR_TMO;
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_POLL;
                    end
                end else if (mst_rdata_s[SR_ARBL]) begin
                    // Bus is no longer ours: no STOP can be issued
                    err_d   = ERR_ARB;
                    state_d = ST_DONE;
                end else if ((step_q != 2'd3) && mst_rdata_s[SR_RARC]) begin
                    err_d   = ERR_NACK;
                    state_d = ST_STOP;
                end else if (step_q == 2'd3) begin
                    state_d = ST_RX;
                end else if ((step_q == 2'd2) && !rd_q) begin
                    state_d = ST_STOP;
                end else if (step_q == 2'd2) begin
                    step_d  = 2'd3;
                    state_d = ST_CMD;
                end else begin
                    step_d  = step_q + 2'd1;
                    state_d = ST_TX;
                end
            end
            ST_RX: begin
                mst_start_s = ~mst_busy_s;
                mst_addr_s  = BASE + OFS_RXDR;
                if (mst_done_s) begin
                    rdata_d = mst_rdata_s;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_RX;
                end
            end
            ST_STOP: begin
                mst_start_s = ~mst_busy_s;
                mst_we_s    = 1'b1;
                mst_addr_s  = BASE + OFS_CMDR;
                mst_wdata_s = CMDR_STOP;
                if (mst_done_s) begin
                    state_d    = ST_STOP_POLL;
                    poll_cnt_d = 16'd0;
                end else begin
                    state_d    = ST_STOP;
                end
            end
            ST_STOP_POLL: begin
                mst_start_s = ~mst_busy_s;
                mst_addr_s  = BASE + OFS_SR;
                if (!mst_done_s) begin
                    state_d = ST_STOP_POLL;
                end else if (!mst_rdata_s[SR_BUSY]) begin
                    state_d = ST_DONE;
                end else begin
                    poll_cnt_d = poll_inc_s;
                    if (poll_inc_s >= POLL_MAX) begin
                        // An earlier error is more informative than the stop timeout
                        err_d   = (err_q == ERR_OK) ? ERR_TMO : err_q;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STOP_POLL;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
                step_d  = 2'd0;
            end
        endcase

        rsp_valid_d = (state_d == ST_DONE);
        rsp_err_d   = (state_d == ST_DONE) ? err_d : 2'd0;
        rsp_rdata_d = ((state_d == ST_DONE) && (err_d == ERR_OK) && rd_q) ? rdata_d : 8'h00;
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Sequencer state and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_INIT;
            step_q      <= 2'd0;
            rd_q        <= 1'b0;
            dev_q       <= 7'd0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            err_q       <= ERR_OK;
            poll_cnt_q  <= 16'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 2'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            rd_q        <= rd_d;
            dev_q       <= dev_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            poll_cnt_q  <= poll_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_lat_seq.sv
// Directed bench for i2c_lat_seq with a behavioural I2C core + i2c_mem model at 0x50.
module tb_i2c_lat_seq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid, cmd_ready, cmd_rd;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       lat_stb, lat_we, lat_ack, busy;
    logic [7:0] lat_addr, lat_wdata, lat_rdata;

    always #5 clk = ~clk;

    i2c_lat_seq #(.BASE(8'h40), .PRESCALE(10'h1C3), .POLL_MAX(16'd8)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_dev(cmd_dev), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .lat_stb(lat_stb), .lat_we(lat_we), .lat_addr(lat_addr), .lat_wdata(lat_wdata),
        .lat_rdata(lat_rdata), .lat_ack(lat_ack), .busy(busy)
    );

    // ---------------- core / memory model ----------------
    int         ack_delay = 0;
    bit         stuck_mode = 1'b0;
    bit         arb_mode = 1'b0;
    int         wait_cnt = 0;
    int         ack_total = 0;
    int         sr_reads = 0;
    int         stop_sr = 0;
    int         txdr_cnt = 0;
    logic [7:0] txdr = 8'h00, rxdr = 8'h00, ptr = 8'h00;
    logic       nack = 1'b0, got_ptr = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] cmd_log [$];
    logic [15:0] wr_log [$];
    int         rsp_cnt = 0;

    assign lat_ack = lat_stb && (wait_cnt >= ack_delay);

    always_comb begin
        lat_rdata = 8'h00;
        if (lat_addr == 8'h45)
            lat_rdata = {1'b0, 1'b0, nack, 1'b0, arb_mode, ~stuck_mode, 2'b00};
        else if (lat_addr == 8'h47)
            lat_rdata = rxdr;
        else
            lat_rdata = 8'h00;
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= 0;
        end else if (lat_stb && lat_ack) begin
            wait_cnt  <= 0;
            ack_total <= ack_total + 1;
            if (lat_we) begin
                wr_log.push_back({lat_addr, lat_wdata});
                if (lat_addr == 8'h44) begin
                    txdr     <= lat_wdata;
                    txdr_cnt <= txdr_cnt + 1;
                end
                if (lat_addr == 8'h41) begin
                    cmd_log.push_back(lat_wdata);
                    if (lat_wdata == 8'h44) stop_sr <= sr_reads;
                    if (lat_wdata[7]) begin
                        nack    <= (txdr[7:1] != 7'h50);
                        got_ptr <= 1'b0;
                    end else if (lat_wdata[4]) begin
                        if (!got_ptr) begin
                            ptr     <= txdr;
                            got_ptr <= 1'b1;
                        end else begin
                            mem[ptr] <= txdr;
                            ptr      <= ptr + 8'd1;
                        end
                    end else if (lat_wdata[5]) begin
                        rxdr <= mem[ptr];
                    end
                end
            end else if (lat_addr == 8'h45) begin
                sr_reads <= sr_reads + 1;
            end
        end else if (lat_stb) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Bus protocol monitor: payload held while waiting, strobe drops after ack
    int         proto_err = 0;
    logic       hold_pend = 1'b0, drop_pend = 1'b0;
    logic       snap_we = 1'b0;
    logic [7:0] snap_addr = 8'h00, snap_wdata = 8'h00;
    always @(posedge clk) begin
        if (!resetn) begin
            hold_pend <= 1'b0;
            drop_pend <= 1'b0;
        end else begin
            if (hold_pend && (lat_stb !== 1'b1 || lat_we !== snap_we ||
                              lat_addr !== snap_addr || lat_wdata !== snap_wdata))
                proto_err <= proto_err + 1;
            if (drop_pend && lat_stb !== 1'b0)
                proto_err <= proto_err + 1;
            hold_pend  <= lat_stb && !lat_ack;
            drop_pend  <= lat_stb && lat_ack;
            snap_we    <= lat_we;
            snap_addr  <= lat_addr;
            snap_wdata <= lat_wdata;
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic collect_seq(input int base, output logic [63:0] seq, output int len);
        seq = 64'd0;
        len = cmd_log.size() - base;
        for (int i = base; i < cmd_log.size(); i++) seq = {seq[55:0], cmd_log[i]};
    endtask

    function automatic logic [63:0] exp_seq(input logic rd, input logic [1:0] err);
        if (err == 2'd3)      return 64'h94;
        else if (err != 2'd0) return 64'h9444;
        else if (rd)          return 64'h94_14_94_2C_44;
        else                  return 64'h94_14_14_44;
    endfunction

    task automatic wait_init(input int ack_base, input int wr_base);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (cmd_ready) seen = 1'b1;
        end
        check("init_ready", 64'(seen), 64'd1);
        check("init_acks_at_ready", 64'(ack_total - ack_base), 64'd3);
        check("init_wr0", 64'(wr_log[wr_base]),     64'h42C3);
        check("init_wr1", 64'(wr_log[wr_base + 1]), 64'h4301);
        check("init_wr2", 64'(wr_log[wr_base + 2]), 64'h4080);
    endtask

    task automatic run_cmd(input string name, input logic rd, input logic [6:0] dev,
                           input logic [7:0] addr, input logic [7:0] wdata, input int junk,
                           output logic [1:0] err, output logic [7:0] rdata);
        bit got;
        got = 1'b0;
        err = 2'd0;
        rdata = 8'h00;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        check({name, "_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_rd = rd; cmd_dev = dev; cmd_addr = addr; cmd_wdata = wdata;
        @(negedge clk);
        // Keep requesting with different fields while busy; must be ignored
        cmd_rd = ~rd; cmd_dev = 7'h23; cmd_addr = 8'hEE; cmd_wdata = 8'h11;
        for (int i = 0; i < junk; i++) @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        check({name, "_rsp_seen"}, 64'(got), 64'd1);
        if (got) begin
            err   = rsp_err;
            rdata = rsp_rdata;
            check({name, "_ready_during_rsp"}, 64'(cmd_ready), 64'd0);
            @(negedge clk);
            check({name, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
            check({name, "_ready_after_rsp"}, 64'(cmd_ready), 64'd1);
        end
    endtask

    typedef struct {
        logic       rd;
        logic [6:0] dev;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         dly;
        logic [1:0] exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [1:0]  e;
        logic [7:0]  d;
        logic [63:0] seq;
        int          len, lbase, tbase, sbase, ab, wb, rb;
        bit          hit;

        vecs[0] = '{1'b0, 7'h50, 8'h12, 8'hA5, 0, 2'd0, 8'h00};
        vecs[1] = '{1'b1, 7'h50, 8'h12, 8'h00, 0, 2'd0, 8'hA5};
        vecs[2] = '{1'b0, 7'h50, 8'h34, 8'h5C, 2, 2'd0, 8'h00};
        vecs[3] = '{1'b1, 7'h50, 8'h34, 8'h00, 1, 2'd0, 8'h5C};
        vecs[4] = '{1'b0, 7'h23, 8'h12, 8'h77, 0, 2'd1, 8'h00};
        vecs[5] = '{1'b1, 7'h23, 8'h12, 8'h00, 0, 2'd1, 8'h00};
        vecs[6] = '{1'b1, 7'h50, 8'h12, 8'h00, 3, 2'd0, 8'hA5};

        resetn = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0;
        cmd_dev = 7'd0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_lat_stb",   64'(lat_stb),   64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        ab = ack_total; wb = wr_log.size();
        resetn = 1'b1;
        wait_init(ab, wb);

        for (int v = 0; v < 7; v++) begin
            ack_delay = vecs[v].dly;
            lbase = cmd_log.size(); tbase = txdr_cnt;
            run_cmd($sformatf("vec%0d", v), vecs[v].rd, vecs[v].dev, vecs[v].addr,
                    vecs[v].wdata, 0, e, d);
            check($sformatf("vec%0d_err", v), 64'(e), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d_rdata", v), 64'(d), 64'(vecs[v].exp_rdata));
            collect_seq(lbase, seq, len);
            check($sformatf("vec%0d_cmdr_seq", v), seq, exp_seq(vecs[v].rd, vecs[v].exp_err));
            if (vecs[v].exp_err == 2'd1)
                check($sformatf("vec%0d_txdr_writes", v), 64'(txdr_cnt - tbase), 64'd1);
            else if (!vecs[v].rd)
                check($sformatf("vec%0d_mem", v), 64'(mem[vecs[v].addr]), 64'(vecs[v].wdata));
            else
                check($sformatf("vec%0d_cmdr_len", v), 64'(len), 64'd5);
        end
        ack_delay = 0;

        // Command held valid while busy is neither captured nor queued
        rb = rsp_cnt; lbase = cmd_log.size();
        run_cmd("busy_ignore", 1'b0, 7'h50, 8'h77, 8'hE1, 6, e, d);
        repeat (30) @(negedge clk);
        check("busy_ignore_err", 64'(e), 64'd0);
        check("busy_ignore_mem", 64'(mem[8'h77]), 64'hE1);
        collect_seq(lbase, seq, len);
        check("busy_ignore_seq", seq, 64'h94_14_14_44);
        check("busy_ignore_one_rsp", 64'(rsp_cnt - rb), 64'd1);

        // TRRDY never set: POLL_MAX SR reads, then STOP
        stuck_mode = 1'b1;
        lbase = cmd_log.size(); sbase = sr_reads;
        run_cmd("tmo", 1'b0, 7'h50, 8'h12, 8'h99, 0, e, d);
        stuck_mode = 1'b0;
        check("tmo_err", 64'(e), 64'd2);
        check("tmo_rdata", 64'(d), 64'd0);
        check("tmo_sr_reads", 64'(stop_sr - sbase), 64'd8);
        collect_seq(lbase, seq, len);
        check("tmo_seq", seq, 64'h9444);
        check("tmo_mem_kept", 64'(mem[8'h12]), 64'hA5);

        // Arbitration lost: straight to response, no STOP
        arb_mode = 1'b1;
        lbase = cmd_log.size();
        run_cmd("arb", 1'b1, 7'h50, 8'h12, 8'h00, 0, e, d);
        arb_mode = 1'b0;
        check("arb_err", 64'(e), 64'd3);
        check("arb_rdata", 64'(d), 64'd0);
        collect_seq(lbase, seq, len);
        check("arb_seq", seq, 64'h94);

        // Reset while a read access is outstanding
        ack_delay = 2;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        lbase = cmd_log.size();
        cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_dev = 7'h50; cmd_addr = 8'h12;
        @(negedge clk);
        cmd_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            if (lat_stb && (cmd_log.size() - lbase >= 3)) hit = 1'b1;
            else @(negedge clk);
        end
        check("midrst_reached", 64'(hit), 64'd1);
        resetn = 1'b0;
        #1;
        check("midrst_lat_stb",   64'(lat_stb),   64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("midrst_busy",      64'(busy),      64'd0);
        ack_delay = 0;
        repeat (3) @(negedge clk);
        ab = ack_total; wb = wr_log.size();
        resetn = 1'b1;
        wait_init(ab, wb);
        run_cmd("post_rst", 1'b0, 7'h50, 8'h56, 8'h3C, 0, e, d);
        check("post_rst_err", 64'(e), 64'd0);
        check("post_rst_mem", 64'(mem[8'h56]), 64'h3C);

        repeat (5) @(negedge clk);
        check("bus_protocol", 64'(proto_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
